// File: rtl/bp_cce_cfg_link_arbiter.sv
// Round-robin arbiter sharing one CCE config link among num_req_p requesters.
// Writes are fire-and-forget; a read holds the link until its response is consumed.
module bp_cce_cfg_link_arbiter #(
  parameter int num_req_p             = 2,
  parameter int cfg_link_addr_width_p = 16,
  parameter int cfg_link_data_width_p = 32
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic [num_req_p*(cfg_link_addr_width_p-1)-1:0] req_addr_i,
  input  logic [num_req_p*cfg_link_data_width_p-1:0]     req_data_i,
  input  logic [num_req_p-1:0]                           req_v_i,
  input  logic [num_req_p-1:0]                           req_w_i,
  output logic [num_req_p-1:0]                           req_ready_o,
  output logic [cfg_link_data_width_p-1:0]               resp_data_o,
  output logic [num_req_p-1:0]                           resp_v_o,
  input  logic [num_req_p-1:0]                           resp_ready_i,
  output logic [cfg_link_addr_width_p-2:0]               config_addr_o,
  output logic [cfg_link_data_width_p-1:0]               config_data_o,
  output logic                                           config_v_o,
  output logic                                           config_w_o,
  input  logic                                           config_ready_i,
  input  logic [cfg_link_data_width_p-1:0]               config_data_i,
  input  logic                                           config_v_i,
  output logic                                           config_ready_o
);
  localparam int lw_lp = cfg_link_addr_width_p - 1;
  localparam int dw_lp = cfg_link_data_width_p;
  localparam int rw_lp = $clog2(num_req_p);

  typedef enum logic [1:0] {e_idle, e_rd_wait, e_rd_resp} state_e;

  state_e             state_q, state_d;
  logic [rw_lp-1:0]   rr_q, rr_d, owner_q, owner_d, gnt;
  logic [dw_lp-1:0]   resp_q, resp_d;
  logic               any_v, hs;

  assign any_v = |req_v_i;

  // Scan from the far end so the requester closest to rr_q is the last (winning) assignment.
  always_comb begin
    gnt = rr_q;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (req_v_i[(int'(rr_q) + k) % num_req_p])
        gnt = rw_lp'((int'(rr_q) + k) % num_req_p);
    end
  end

  always_comb begin
    req_ready_o    = '0;
    resp_v_o       = '0;
    resp_data_o    = '0;
    config_addr_o  = '0;
    config_data_o  = '0;
    config_v_o     = 1'b0;
    config_w_o     = 1'b0;
    config_ready_o = 1'b0;
    hs             = 1'b0;
    if (!reset_i) begin
      resp_data_o = resp_q;
      case (state_q)
        e_idle: begin
          if (any_v) begin
            config_v_o    = 1'b1;
            config_addr_o = req_addr_i[int'(gnt)*lw_lp +: lw_lp];
            config_data_o = req_data_i[int'(gnt)*dw_lp +: dw_lp];
            config_w_o    = req_w_i[gnt];
            // Only the granted requester sees the link ready.
            req_ready_o[gnt] = config_ready_i;
            hs               = config_ready_i;
          end
        end
        e_rd_wait: config_ready_o = 1'b1;
        e_rd_resp: resp_v_o[owner_q] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    resp_d  = resp_q;
    case (state_q)
      e_idle: begin
        if (hs) begin
          rr_d = (int'(gnt) == num_req_p - 1) ? '0 : rw_lp'(gnt + 1'b1);
          if (!req_w_i[gnt]) begin
            owner_d = gnt;
            state_d = e_rd_wait;
          end
        end
      end
      e_rd_wait: begin
        if (config_v_i) begin
          resp_d  = config_data_i;
          state_d = e_rd_resp;
        end
      end
      e_rd_resp: if (resp_ready_i[owner_q]) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      rr_q    <= '0;
      owner_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_bp_cce_cfg_link_arbiter.sv
// Randomized scoreboard bench for bp_cce_cfg_link_arbiter: a transaction-level model
// predicts grants and read responses; a negedge monitor compares the DUT against them.
module tb_bp_cce_cfg_link_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = AW - 1;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N*LW-1:0] req_addr_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_v_i, req_w_i, req_ready_o, resp_v_o, resp_ready_i;
  logic [DW-1:0]   resp_data_o, config_data_o, config_data_i;
  logic [LW-1:0]   config_addr_o;
  logic            config_v_o, config_w_o, config_ready_i, config_v_i, config_ready_o;

  bp_cce_cfg_link_arbiter #(
    .num_req_p(N), .cfg_link_addr_width_p(AW), .cfg_link_data_width_p(DW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_v_i(req_v_i), .req_w_i(req_w_i),
    .req_ready_o(req_ready_o), .resp_data_o(resp_data_o), .resp_v_o(resp_v_o),
    .resp_ready_i(resp_ready_i), .config_addr_o(config_addr_o), .config_data_o(config_data_o),
    .config_v_o(config_v_o), .config_w_o(config_w_o), .config_ready_i(config_ready_i),
    .config_data_i(config_data_i), .config_v_i(config_v_i), .config_ready_o(config_ready_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    id;
    logic [LW-1:0] addr;
    logic [DW-1:0] data;
    logic          w;
  } link_t;

  typedef struct packed {
    logic [7:0]    id;
    logic [DW-1:0] data;
  } rsp_t;

  link_t exp_link[$];
  rsp_t  exp_rsp[$];

  // Per-cycle expectations published by the stimulus process just after each posedge.
  logic          exp_rst, exp_cfg_v, exp_cfg_rdy, chk_en;
  logic [N-1:0]  exp_rdy, exp_rv;
  link_t         exp_cur;

  int total = 0;
  int bad   = 0;
  int n_rsp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int scan(input logic [N-1:0] p, input int r);
    for (int k = 0; k < N; k++)
      if (p[(r + k) % N]) return (r + k) % N;
    return 0;
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [N-1:0] oh;
    if (chk_en) begin
      if (exp_rst) begin
        chk("rst_ctl", {config_v_o, config_w_o, config_ready_o, req_ready_o, resp_v_o, config_addr_o}, '0);
        chk("rst_data", {resp_data_o, config_data_o}, '0);
      end else begin
        chk("config_v", config_v_o, exp_cfg_v);
        chk("req_ready", req_ready_o, exp_rdy);
        chk("config_ready_o", config_ready_o, exp_cfg_rdy);
        chk("resp_v", resp_v_o, exp_rv);
        if (exp_cfg_v) begin
          chk("cfg_addr", config_addr_o, exp_cur.addr);
          chk("cfg_data", config_data_o, exp_cur.data);
          chk("cfg_w", config_w_o, exp_cur.w);
        end else begin
          chk("cfg_idle_zero", {config_addr_o, config_w_o, config_data_o}, '0);
        end
        if (config_v_o && config_ready_i) begin
          chk("link_expected", exp_link.size() > 0, 1'b1);
          if (exp_link.size() > 0) begin
            link_t e;
            e  = exp_link.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            chk("link_grant", req_ready_o, oh);
            chk("link_addr", config_addr_o, e.addr);
          end
        end
        if (resp_v_o != '0) begin
          chk("rsp_expected", exp_rsp.size() > 0, 1'b1);
          if (exp_rsp.size() > 0) begin
            oh = '0;
            oh[exp_rsp[0].id] = 1'b1;
            chk("rsp_owner", resp_v_o, oh);
            chk("rsp_data", resp_data_o, exp_rsp[0].data);
            if ((resp_v_o & resp_ready_i) != '0) begin
              void'(exp_rsp.pop_front());
              n_rsp++;
            end
          end
        end
      end
    end
  end

  // Stimulus + transaction-level model
  logic [N-1:0]  pend;
  logic [LW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];
  logic          p_w    [N];
  int ph, rr, owner, lat, n_rst, g;
  bit late;

  task automatic step(input int mode);
    int  rate, wpct, rdy;
    bit  rst;
    rst  = 1'b0;
    case (mode)
      0:       begin rate = 100; wpct = 100; rdy = 100; end
      1:       begin rate = 100; wpct = 100; rdy = 100; end
      2:       begin rate = 40;  wpct = 60;  rdy = 75;  end
      default: begin rate = 0;   wpct = 0;   rdy = 100; end
    endcase
    if (mode == 2 && ph == 1 && n_rst < 4 && $urandom_range(0, 9) == 0) rst = 1'b1;

    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (mode != 0 || i == 0) && $urandom_range(0, 99) < rate) begin
        pend[i]   = 1'b1;
        p_addr[i] = LW'($urandom);
        p_data[i] = $urandom;
        p_w[i]    = ($urandom_range(0, 99) < wpct);
      end
      req_addr_i[i*LW +: LW] = p_addr[i];
      req_data_i[i*DW +: DW] = p_data[i];
      req_w_i[i]             = p_w[i];
    end
    req_v_i        = pend;
    config_ready_i = ($urandom_range(0, 99) < rdy);
    resp_ready_i   = (mode == 3) ? '1 : N'($urandom);

    config_v_i    = 1'b0;
    config_data_i = $urandom;
    if (ph == 1) begin
      if (lat == 0) config_v_i = 1'b1;
      else lat--;
    end else if (late || (mode == 2 && $urandom_range(0, 7) == 0)) begin
      config_v_i = 1'b1;
    end
    late = 1'b0;

    reset_i     = rst;
    exp_rst     = rst;
    exp_rdy     = '0;
    exp_rv      = '0;
    exp_cfg_v   = 1'b0;
    exp_cfg_rdy = 1'b0;
    if (rst) begin
      ph = 0; rr = 0; owner = 0;
      exp_rsp.delete();
      late = 1'b1;
      n_rst++;
    end else begin
      case (ph)
        0: begin
          if (pend != '0) begin
            g         = scan(pend, rr);
            exp_cfg_v = 1'b1;
            exp_cur   = '{id: 8'(g), addr: p_addr[g], data: p_data[g], w: p_w[g]};
            if (config_ready_i) begin
              exp_rdy[g] = 1'b1;
              exp_link.push_back(exp_cur);
              pend[g] = 1'b0;
              rr      = (g + 1) % N;
              if (!p_w[g]) begin
                owner = g;
                lat   = $urandom_range(0, 3);
                ph    = 1;
              end
            end
          end
        end
        1: begin
          exp_cfg_rdy = 1'b1;
          if (config_v_i) begin
            exp_rsp.push_back('{id: 8'(owner), data: config_data_i});
            ph = 2;
          end
        end
        default: begin
          exp_rv[owner] = 1'b1;
          if (resp_ready_i[owner]) ph = 0;
        end
      endcase
    end
  endtask

  initial begin
    reset_i = 1'b1; req_addr_i = '0; req_data_i = '0; req_v_i = '0; req_w_i = '0;
    resp_ready_i = '0; config_ready_i = 1'b0; config_data_i = '0; config_v_i = 1'b0;
    pend = '0; ph = 0; rr = 0; owner = 0; lat = 0; n_rst = 0; late = 1'b0; g = 0;
    for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_data[i] = '0; p_w[i] = 1'b0; end
    exp_rst = 1'b1; exp_cfg_v = 1'b0; exp_cfg_rdy = 1'b0; exp_rdy = '0; exp_rv = '0;
    exp_cur = '0; chk_en = 1'b1;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      step(cyc < 200 ? 0 : (cyc < 800 ? 1 : 2));
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      step(3);
    end
    @(negedge clk); #1;
    chk("link_queue_drained", exp_link.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    chk("responses_seen", n_rsp > 10, 1'b1);
    chk("resets_seen", n_rst > 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
